fp_cmp_reduce_pipe: RTL and testbench
=====================================

// Module: fp_cmp_reduce_pipe
// PURPOSE
//  Pipelined, parametrised comparator for FloPoCo-format floats {exc[1:0],sign,exp[WE-1:0],frac[WF-1:0]}.
//  Compares operands directly, with no FP subtractor in the path.
//  Outputs GT/GE/EQ/LT flags, an unordered flag, and the min/max operand.
//  Optional grouped reduction (running max or min) feeds the ray/AABB slab test (tnear=max, tfar=min).
//  Sits between the slab t-computation units and the hit decision logic.
// PARAMETERS
//  WE      11  exponent width
//  WF      6   fraction width
//  STAGES  2   pipeline depth, 1..3; total latency = STAGES cycles
//  (derived) W = WE+WF+3, full operand width
// PORTS
//  clk        in   1  clock
//  rst        in   1  asynchronous active-high reset
//  in_valid   in   1  operands valid this cycle
//  inA        in   W  operand A
//  inB        in   W  operand B (ignored when red_en=1)
//  red_en     in   1  reduction mode for this beat
//  red_max    in   1  1=reduce to max, 0=reduce to min (sampled on in_first beat)
//  in_first   in   1  first beat of a reduction group
//  in_last    in   1  last beat of a reduction group
//  out_valid  out  1  compare results valid
//  gt,ge,eq,lt out 1 each  A>B, A>=B, A==B, A<B
//  unordered  out  1  either operand NaN
//  max_out    out  W  larger operand
//  min_out    out  W  smaller operand
//  red_valid  out  1  one-cycle pulse: reduction result ready
//  red_out    out  W  reduction result
//  red_nan    out  1  a NaN was seen in the group
// BEHAVIOUR
//  Reset: all outputs 0; accumulator 0; group-active flag 0; red_max reg 0. All regs on posedge clk or posedge rst.
//  Exception encoding: 00 zero, 01 normal, 10 inf, 11 NaN.
//  Ordering key:
//   - zero maps to magnitude 0 regardless of sign, so +0 == -0.
//   - inf is above every normal of the same sign.
//   - normals order by {exp,frac} magnitude; sign flips the order.
//  Stage 1 registers the operands and key compare; later stages are pure delay registers.
//  in_valid is carried through the same STAGES registers and appears as out_valid.
//  No back-pressure: one beat per cycle, sustained throughput 1/cycle.
//  NaN on either side: unordered=1, gt=ge=eq=lt=0, max_out=min_out=NaN operand (inA if both NaN).
//  Equal operands: eq=ge=1; max_out=min_out=inA.
//  Outputs hold their last values while out_valid=0.
//  Reduction (red_en=1): each beat compares inA against the accumulator at the output stage.
//   - in_first: accumulator := inA; red_max latched; red_nan := (inA is NaN); group active := 1.
//   - Other beats with group active: accumulator := max or min (acc, inA).
//     A NaN operand sets red_nan sticky and leaves the accumulator unchanged.
//   - in_last (may coincide with in_first): red_valid=1 for one cycle with red_out = updated accumulator; group active := 0.
//   - red_out holds its value until the next red_valid.
//   - Beat with red_en=1 and no active group and no in_first: ignored by the reducer; compare flags still produced.
//   - in_first while a group is active: the old group is discarded without red_valid; a new group starts.
//  red_en=0 beats never touch the accumulator, even mid-group.
//  Reset mid-group: the group is discarded and no red_valid is emitted.
// TESTING (WE=11,WF=6: +1.0=0x4FFC0, +2.0=0x50000, -1.0=0x6FFC0, +0=0x00000, -0=0x20000, +inf=0x80000, NaN=0xC0000)
//  A=0x50000,B=0x4FFC0 -> after STAGES cycles: gt=ge=1, eq=lt=0, max_out=0x50000, min_out=0x4FFC0.
//  A=0x00000,B=0x20000 -> eq=ge=1, gt=lt=0; A=0x6FFC0,B=0x00000 -> lt=1.
//  A=0xC0000,B=0x4FFC0 -> unordered=1, all flags 0; A=0x80000,B=0x50000 -> gt=1.
//  Reduction max over 0x4FFC0 (first), 0x6FFC0, 0x50000 (last) -> single red_valid, red_out=0x50000, red_nan=0.
//  Reduction min group with a NaN mid-beat -> red_nan=1, red_out=min of non-NaN beats.
//  Back-to-back beats every cycle for 100 random pairs vs reference model; assert rst mid-group -> no red_valid.

Source files
------------

// File: rtl/fp_cmp_reduce_pipe.sv
// Pipelined FloPoCo float comparator with GT/GE/EQ/LT, unordered, min/max
// and a grouped running max/min reducer for slab tests.
// Ports: clk, rst (async high); in_valid, inA, inB, red_en, red_max,
//   in_first, in_last in; out_valid, gt, ge, eq, lt, unordered, max_out,
//   min_out, red_valid, red_out, red_nan out. Latency = STAGES cycles.
module fp_cmp_reduce_pipe #(
  parameter  int WE     = 11,
  parameter  int WF     = 6,
  parameter  int STAGES = 2,
  localparam int W      = WE + WF + 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         red_en,
  input  logic         red_max,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  output logic         gt,
  output logic         ge,
  output logic         eq,
  output logic         lt,
  output logic         unordered,
  output logic [W-1:0] max_out,
  output logic [W-1:0] min_out,
  output logic         red_valid,
  output logic [W-1:0] red_out,
  output logic         red_nan
);

  typedef struct packed {
    logic         v;
    logic         gt;
    logic         ge;
    logic         eq;
    logic         lt;
    logic         un;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
    logic [W-1:0] a;
    logic         ren;
    logic         rmax;
    logic         first;
    logic         last;
  } beat_t;

  function automatic logic is_nan(input logic [W-1:0] x);
    return x[W-1:W-2] == 2'b11;
  endfunction

  // Map an operand to an unsigned key whose integer order is the float
  // order: magnitude = {class, exp, frac}; negatives are bit-inverted
  // below the positive half. Zero of either sign lands on {1, 0...}.
  function automatic logic [W-1:0] okey(input logic [W-1:0] x);
    logic [W-2:0] mag;
    unique case (x[W-1:W-2])
      2'b00:   mag = '0;
      2'b01:   mag = {2'b01, x[WE+WF-1:0]};
      default: mag = {2'b10, {(WE+WF){1'b0}}};
    endcase
    if (x[W-3] && (x[W-1:W-2] != 2'b00)) return {1'b0, ~mag};
    return {1'b1, mag};
  endfunction

  logic [W-1:0] ka;
  logic [W-1:0] kb;
  logic         na;
  logic         nb;
  beat_t        r0;

  assign ka = okey(inA);
  assign kb = okey(inB);
  assign na = is_nan(inA);
  assign nb = is_nan(inB);

  always_comb begin
    r0       = '0;
    r0.v     = in_valid;
    r0.a     = inA;
    r0.ren   = red_en;
    r0.rmax  = red_max;
    r0.first = in_first;
    r0.last  = in_last;
    r0.un    = na | nb;
    if (na | nb) begin
      r0.mx = na ? inA : inB;
      r0.mn = na ? inA : inB;
    end else begin
      r0.gt = ka > kb;
      r0.eq = ka == kb;
      r0.lt = ka < kb;
      r0.ge = (ka > kb) | (ka == kb);
      r0.mx = (ka < kb) ? inB : inA;
      r0.mn = (ka > kb) ? inB : inA;
    end
  end

  // Data only advances with a valid beat so the last result holds.
  beat_t rq [1:STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) rq[k] <= '0;
    end else begin
      rq[1].v <= r0.v;
      if (r0.v) rq[1] <= r0;
      for (int k = 2; k <= STAGES; k++) begin
        rq[k].v <= rq[k-1].v;
        if (rq[k-1].v) rq[k] <= rq[k-1];
      end
    end
  end

  assign out_valid = rq[STAGES].v;
  assign gt        = rq[STAGES].gt;
  assign ge        = rq[STAGES].ge;
  assign eq        = rq[STAGES].eq;
  assign lt        = rq[STAGES].lt;
  assign unordered = rq[STAGES].un;
  assign max_out   = rq[STAGES].mx;
  assign min_out   = rq[STAGES].mn;

  // Reducer updates on the same edge that loads the output stage, so
  // red_valid lines up with the out_valid of the group's last beat.
  beat_t pre;

  generate
    if (STAGES == 1) begin : g_pre1
      assign pre = r0;
    end else begin : g_pren
      assign pre = rq[STAGES-1];
    end
  endgenerate

  logic [W-1:0] acc;
  logic [W-1:0] acc_n;
  logic         act;
  logic         act_n;
  logic         rmax_q;
  logic         rmax_n;
  logic         snan;
  logic         snan_n;
  logic         rv_n;
  logic         take;
  logic         better;
  logic [W-1:0] kp;
  logic [W-1:0] kacc;

  assign kp     = okey(pre.a);
  assign kacc   = okey(acc);
  assign better = rmax_q ? (kp > kacc) : (kp < kacc);
  assign take   = pre.v & pre.ren & (pre.first | act);

  always_comb begin
    acc_n  = acc;
    act_n  = act;
    rmax_n = rmax_q;
    snan_n = snan;
    rv_n   = 1'b0;
    if (pre.v & pre.ren & pre.first) begin
      acc_n  = pre.a;
      rmax_n = pre.rmax;
      snan_n = is_nan(pre.a);
      act_n  = 1'b1;
    end else if (take) begin
      // A NaN-seeded accumulator is replaced by the first real value.
      if (is_nan(pre.a)) snan_n = 1'b1;
      else if (is_nan(acc) || better) acc_n = pre.a;
    end
    if (take & pre.last) begin
      rv_n  = 1'b1;
      act_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      act       <= 1'b0;
      rmax_q    <= 1'b0;
      snan      <= 1'b0;
      red_valid <= 1'b0;
      red_out   <= '0;
      red_nan   <= 1'b0;
    end else begin
      acc       <= acc_n;
      act       <= act_n;
      rmax_q    <= rmax_n;
      snan      <= snan_n;
      red_valid <= rv_n;
      if (rv_n) begin
        red_out <= acc_n;
        red_nan <= snan_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmp_reduce_pipe.sv
// Self-checking bench for fp_cmp_reduce_pipe: directed cases plus random
// back-to-back beats against a rank-based reference model.
module tb_fp_cmp_reduce_pipe;

  localparam int WE = 11;
  localparam int WF = 6;
  localparam int ST = 2;
  localparam int W  = WE + WF + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic         red_en = 1'b0;
  logic         red_max = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         gt;
  logic         ge;
  logic         eq;
  logic         lt;
  logic         unordered;
  logic [W-1:0] max_out;
  logic [W-1:0] min_out;
  logic         red_valid;
  logic [W-1:0] red_out;
  logic         red_nan;

  fp_cmp_reduce_pipe #(.WE(WE), .WF(WF), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inA(inA), .inB(inB),
    .red_en(red_en), .red_max(red_max), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid), .gt(gt), .ge(ge), .eq(eq),
    .lt(lt), .unordered(unordered), .max_out(max_out), .min_out(min_out),
    .red_valid(red_valid), .red_out(red_out), .red_nan(red_nan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ren;
    logic         rmax;
    logic         first;
    logic         last;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;
  int rv_seen = 0;

  beat_t        hist[$];
  logic         e_gt, e_ge, e_eq, e_lt, e_un;
  logic [W-1:0] e_mx, e_mn, e_rout;
  logic         e_rnan;
  logic         g_act;
  logic         g_max;
  logic [W-1:0] g_vals[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic isnan(input logic [W-1:0] x);
    return x[W-1:W-2] == 2'b11;
  endfunction

  // Signed integer rank of a non-NaN value in float order.
  function automatic longint rank(input logic [W-1:0] x);
    longint m;
    case (x[W-1:W-2])
      2'b00:   m = 0;
      2'b01:   m = longint'(x[WE+WF-1:0]) + 1;
      default: m = (longint'(1) << (WE + WF)) + 1;
    endcase
    return x[W-3] ? -m : m;
  endfunction

  function automatic logic [W-1:0] rnd_fp();
    int           c = $urandom_range(0, 7);
    logic         s = 1'($urandom_range(0, 1));
    logic [10:0]  e = 11'($urandom_range(1021, 1025));
    logic [5:0]   f = 6'($urandom_range(0, 3));
    case (c)
      0:       return {2'b00, s, 17'd0};
      6:       return {2'b10, s, 17'd0};
      7:       return {2'b11, s, 17'd0};
      default: return {2'b01, s, e, f};
    endcase
  endfunction

  function automatic beat_t mk(input logic v, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic ren,
                               input logic rmax, input logic first,
                               input logic last);
    beat_t t;
    t.v = v; t.a = a; t.b = b; t.ren = ren;
    t.rmax = rmax; t.first = first; t.last = last;
    return t;
  endfunction

  task automatic model_cmp(input beat_t t);
    longint ra, rb;
    e_un = isnan(t.a) | isnan(t.b);
    if (e_un) begin
      {e_gt, e_ge, e_eq, e_lt} = 4'b0;
      e_mx = isnan(t.a) ? t.a : t.b;
      e_mn = e_mx;
    end else begin
      ra = rank(t.a);
      rb = rank(t.b);
      e_gt = ra > rb;
      e_eq = ra == rb;
      e_lt = ra < rb;
      e_ge = ra >= rb;
      e_mx = (ra < rb) ? t.b : t.a;
      e_mn = (ra > rb) ? t.b : t.a;
    end
  endtask

  task automatic model_red(input beat_t t, output logic rv);
    logic         took;
    logic [W-1:0] res;
    logic         have;
    logic         ns;
    rv   = 1'b0;
    took = t.first | g_act;
    if (t.first) begin
      g_act = 1'b1;
      g_max = t.rmax;
      g_vals.delete();
      g_vals.push_back(t.a);
    end else if (g_act) begin
      g_vals.push_back(t.a);
    end
    if (took && t.last) begin
      res  = g_vals[0];
      have = !isnan(res);
      ns   = isnan(res);
      for (int i = 1; i < g_vals.size(); i++) begin
        if (isnan(g_vals[i])) ns = 1'b1;
        else if (!have || (g_max ? rank(g_vals[i]) > rank(res)
                                 : rank(g_vals[i]) < rank(res))) begin
          res  = g_vals[i];
          have = 1'b1;
        end
      end
      rv     = 1'b1;
      e_rout = res;
      e_rnan = ns;
      g_act  = 1'b0;
    end
  endtask

  task automatic step(input beat_t bt);
    beat_t cur;
    logic  erv;
    in_valid = bt.v;
    inA      = bt.a;
    inB      = bt.b;
    red_en   = bt.ren;
    red_max  = bt.rmax;
    in_first = bt.first;
    in_last  = bt.last;
    @(posedge clk);
    hist.push_back(bt);
    #1;
    cur = '0;
    if (hist.size() >= ST) cur = hist[hist.size() - ST];
    while (hist.size() > ST) void'(hist.pop_front());
    erv = 1'b0;
    if (cur.v) begin
      model_cmp(cur);
      if (cur.ren) model_red(cur, erv);
    end
    chk("out_valid", 32'(out_valid), 32'(cur.v));
    chk("gt", 32'(gt), 32'(e_gt));
    chk("ge", 32'(ge), 32'(e_ge));
    chk("eq", 32'(eq), 32'(e_eq));
    chk("lt", 32'(lt), 32'(e_lt));
    chk("unordered", 32'(unordered), 32'(e_un));
    chk("max_out", 32'(max_out), 32'(e_mx));
    chk("min_out", 32'(min_out), 32'(e_mn));
    chk("red_valid", 32'(red_valid), 32'(erv));
    chk("red_out", 32'(red_out), 32'(e_rout));
    chk("red_nan", 32'(red_nan), 32'(e_rnan));
    if (red_valid) rv_seen++;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(mk(0, '0, '0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #2;
    hist.delete();
    g_vals.delete();
    g_act = 1'b0;
    g_max = 1'b0;
    {e_gt, e_ge, e_eq, e_lt, e_un, e_rnan} = 6'b0;
    e_mx   = '0;
    e_mn   = '0;
    e_rout = '0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({gt, ge, eq, lt, unordered}), 32'd0);
    chk("rst_max_out", 32'(max_out), 32'd0);
    chk("rst_min_out", 32'(min_out), 32'd0);
    chk("rst_red", 32'({red_valid, red_nan, red_out}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rv0;

  initial begin
    #1;
    do_reset();
    flush(2);

    step(mk(1, 20'h50000, 20'h4FFC0, 0, 0, 0, 0));
    flush(ST + 1);
    chk("d1_flags", 32'({gt, ge, eq, lt}), 32'b1100);
    chk("d1_max", 32'(max_out), 32'h50000);
    chk("d1_min", 32'(min_out), 32'h4FFC0);

    step(mk(1, 20'h00000, 20'h20000, 0, 0, 0, 0));
    flush(ST + 1);
    chk("d2_zero_eq", 32'({gt, ge, eq, lt}), 32'b0110);

    step(mk(1, 20'h6FFC0, 20'h00000, 0, 0, 0, 0));
    flush(ST + 1);
    chk("d3_lt", 32'({gt, ge, eq, lt}), 32'b0001);

    step(mk(1, 20'hC0000, 20'h4FFC0, 0, 0, 0, 0));
    flush(ST + 1);
    chk("d4_unord", 32'({unordered, gt, ge, eq, lt}), 32'b10000);
    chk("d4_max", 32'(max_out), 32'hC0000);

    step(mk(1, 20'h80000, 20'h50000, 0, 0, 0, 0));
    flush(ST + 1);
    chk("d5_inf_gt", 32'({gt, lt}), 32'b10);

    rv0 = rv_seen;
    step(mk(1, 20'h4FFC0, '0, 1, 1, 1, 0));
    step(mk(1, 20'h6FFC0, '0, 1, 0, 0, 0));
    step(mk(1, 20'h50000, '0, 1, 0, 0, 1));
    flush(ST + 2);
    chk("rmax_pulses", 32'(rv_seen - rv0), 32'd1);
    chk("rmax_out", 32'(red_out), 32'h50000);
    chk("rmax_nan", 32'(red_nan), 32'd0);

    rv0 = rv_seen;
    step(mk(1, 20'h50000, '0, 1, 0, 1, 0));
    step(mk(1, 20'hC0000, '0, 1, 1, 0, 0));
    step(mk(1, 20'h0FFC0 | 20'h60000, '0, 0, 0, 0, 0));
    step(mk(1, 20'h6FFC0, '0, 1, 0, 0, 0));
    step(mk(1, 20'h4FFC0, '0, 1, 0, 0, 1));
    flush(ST + 2);
    chk("rmin_pulses", 32'(rv_seen - rv0), 32'd1);
    chk("rmin_out", 32'(red_out), 32'h6FFC0);
    chk("rmin_nan", 32'(red_nan), 32'd1);

    for (int i = 0; i < 100; i++)
      step(mk(1, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0)));
    for (int i = 0; i < 200; i++)
      step(mk(($urandom_range(0, 7) != 0), rnd_fp(), rnd_fp(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)));
    flush(ST + 2);

    rv0 = rv_seen;
    step(mk(1, 20'h4FFC0, '0, 1, 1, 1, 0));
    step(mk(1, 20'h50000, '0, 1, 0, 0, 1));
    do_reset();
    flush(ST + 3);
    chk("rst_mid_group", 32'(rv_seen - rv0), 32'd0);
    chk("rst_red_out", 32'(red_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
